// File: rtl/otp_pkg.sv
// Shared constants, state type and the byte-wide Galois LFSR helper for the one-time-pad cipher.
package otp_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] DEFAULT_TAPS  = 8'hB8;
  localparam logic [LFSR_W-1:0] SEED_FALLBACK = 8'h01;

  typedef enum logic [0:0] {UNSEEDED, RUN} otp_state_t;

  // Eight Galois steps: one full keystream byte per call.
  function automatic logic [LFSR_W-1:0] lfsr_step8(input logic [LFSR_W-1:0] s,
                                                   input logic [LFSR_W-1:0] taps);
    logic [LFSR_W-1:0] v;
    v = s;
    for (int i = 0; i < 8; i++) begin
      v = v[0] ? ((v >> 1) ^ taps) : (v >> 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/one_time_pad_if.sv
// Message/cipher bus of the one-time-pad block; plain exists only when OTP_DECRYPT_EN is defined.
interface one_time_pad_if #(
  parameter int unsigned TEXT_W = 128
);
  logic              en;
  logic [7:0]        seed;
  logic [TEXT_W-1:0] msg;
  logic [TEXT_W-1:0] cipher;
  logic [TEXT_W-1:0] key_o;
  logic              key_ready;
`ifdef OTP_DECRYPT_EN
  logic [TEXT_W-1:0] plain;
`endif

  modport master (
    output en, seed, msg,
    input  cipher, key_o, key_ready
`ifdef OTP_DECRYPT_EN
    , input plain
`endif
  );

  modport slave (
    input  en, seed, msg,
    output cipher, key_o, key_ready
`ifdef OTP_DECRYPT_EN
    , output plain
`endif
  );

endinterface

// File: rtl/otp_shifter.sv
// Keystream generator: seeds the LFSR after reset, then shifts one LFSR byte per enabled cycle
// into the key register and flags key_ready once every byte has been filled.
module otp_shifter
  import otp_pkg::*;
#(
  parameter int unsigned       TEXT_W    = 128,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = DEFAULT_TAPS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [7:0]        seed,
  output logic [TEXT_W-1:0] key,
  output logic              key_ready
);

  localparam int unsigned NBytes = TEXT_W / LFSR_W;
  localparam int unsigned CntW   = $clog2(NBytes + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(NBytes);

  otp_state_t        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [TEXT_W-1:0] key_q, key_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TEXT_W-1:0] key_shift;

  if (TEXT_W == LFSR_W) begin : g_one_byte
    assign key_shift = lfsr_q;
  end else begin : g_multi_byte
    assign key_shift = {key_q[TEXT_W-LFSR_W-1:0], lfsr_q};
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      UNSEEDED: begin
        // A zero seed would lock the LFSR at zero forever.
        lfsr_d  = (seed == '0) ? SEED_FALLBACK : seed;
        state_d = RUN;
      end
      RUN: begin
        if (en) begin
          key_d  = key_shift;
          lfsr_d = lfsr_step8(lfsr_q, LFSR_TAPS);
          if (cnt_q != FullCnt) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= UNSEEDED;
      lfsr_q  <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key       = key_q;
  assign key_ready = (cnt_q == FullCnt);

endmodule

// File: rtl/one_time_pad.sv
// One-time-pad stream cipher top: registers msg ^ key alongside the key that produced it.
// Define OTP_DECRYPT_EN to add the registered loopback output plain = cipher ^ key_o.
module one_time_pad
  import otp_pkg::*;
#(
  parameter int unsigned       TEXT_W    = 128,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = DEFAULT_TAPS
) (
  input  logic           clk,
  input  logic           reset,
  one_time_pad_if.slave  bus
);

  logic [TEXT_W-1:0] key;
  logic              key_ready;
  logic [TEXT_W-1:0] cipher_q, cipher_d;
  logic [TEXT_W-1:0] key_o_q, key_o_d;

  otp_shifter #(
    .TEXT_W    (TEXT_W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .en        (bus.en),
    .seed      (bus.seed),
    .key       (key),
    .key_ready (key_ready)
  );

  // Cipher and key_o run every cycle regardless of en so they stay pairwise aligned.
  always_comb begin
    cipher_d = bus.msg ^ key;
    key_o_d  = key;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cipher_q <= '0;
      key_o_q  <= '0;
    end else begin
      cipher_q <= cipher_d;
      key_o_q  <= key_o_d;
    end
  end

  assign bus.cipher    = cipher_q;
  assign bus.key_o     = key_o_q;
  assign bus.key_ready = key_ready;

`ifdef OTP_DECRYPT_EN
  logic [TEXT_W-1:0] plain_q, plain_d;

  always_comb begin
    plain_d = cipher_q ^ key_o_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      plain_q <= '0;
    end else begin
      plain_q <= plain_d;
    end
  end

  assign bus.plain = plain_q;
`endif

endmodule

// File: tb/tb_one_time_pad.sv
// Directed bench for one_time_pad: seeding, zero seed, round trip, enable hold, key_ready, reset.
module tb_one_time_pad;

  localparam int unsigned TW = 128;
  localparam logic [TW-1:0] MSG_HW = "Hello World!!!!!";

  logic clk;
  logic reset;
  int   total;
  int   bad;

  one_time_pad_if #(.TEXT_W(TW)) bus ();

  one_time_pad #(.TEXT_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across one edge, then releases it just after an edge.
  task automatic restart(input logic [7:0] s);
    reset    = 1'b0;
    bus.seed = s;
    step();
    reset = 1'b1;
  endtask

  logic [TW-1:0] exp_ko [4];
  logic [7:0]    byts [299];
  logic [TW-1:0] m_prev, m_prev2, m_cur;
  int            zeros, per_bad, early_rep, n_en;

  initial begin
    total = 0;
    bad   = 0;
    exp_ko[0] = '0;
    exp_ko[1] = '0;
    exp_ko[2] = 128'h33;
    exp_ko[3] = 128'h3395;

    reset    = 1'b1;
    bus.en   = 1'b0;
    bus.seed = 8'h00;
    bus.msg  = '0;
    #3 reset = 1'b0;
    #1;
    check("rst_cipher", bus.cipher, '0);
    check("rst_key_o", bus.key_o, '0);
    check("rst_ready", {127'b0, bus.key_ready}, '0);
    check("rst_lfsr", dut.u_shifter.lfsr_q, '0);

    // Seed 0x33 with msg held, key_o follows the hand-derived LFSR bytes.
    bus.en  = 1'b1;
    bus.msg = MSG_HW;
    restart(8'h33);
    step();
    check("seed_lfsr_e1", dut.u_shifter.lfsr_q, 128'h33);
    check("seed_cipher_e1", bus.cipher, MSG_HW);
    step();
    check("seed_lfsr_e2", dut.u_shifter.lfsr_q, 128'h95);
    check("seed_key_e2", dut.u_shifter.key_q, 128'h33);
    step();
    check("seed_key_o_e3", bus.key_o, 128'h33);
    check("seed_cipher_e3", bus.cipher, MSG_HW ^ 128'h33);
    step();
    check("seed_key_o_e4", bus.key_o, 128'h3395);
    check("seed_rt_e4", bus.cipher ^ bus.key_o, MSG_HW);
    for (int e = 5; e <= 20; e++) begin
      step();
      check($sformatf("ready_e%0d", e), {127'b0, bus.key_ready}, {127'b0, e >= 17});
      check($sformatf("rt_e%0d", e), bus.cipher ^ bus.key_o, MSG_HW);
    end

    // Async reset between edges clears everything before the next edge.
    #3 reset = 1'b0;
    #1;
    check("arst_cipher", bus.cipher, '0);
    check("arst_key_o", bus.key_o, '0);
    check("arst_ready", {127'b0, bus.key_ready}, '0);
    check("arst_lfsr", dut.u_shifter.lfsr_q, '0);
    bus.seed = 8'h33;
    step();
    reset = 1'b1;
    for (int e = 0; e < 4; e++) begin
      step();
      check($sformatf("rerun_key_o_e%0d", e + 1), bus.key_o, exp_ko[e]);
    end

    // Enable hold: key/lfsr frozen at 33952A / 55 while cipher tracks the changing msg.
    bus.en  = 1'b0;
    m_prev  = MSG_HW;
    m_prev2 = MSG_HW;
    for (int i = 0; i < 5; i++) begin
      m_cur   = {16{8'(8'h10 + i)}};
      bus.msg = m_cur;
      step();
      check($sformatf("hold_key_o_%0d", i), bus.key_o, 128'h33952A);
      check($sformatf("hold_cipher_%0d", i), bus.cipher, m_cur ^ 128'h33952A);
      check($sformatf("hold_lfsr_%0d", i), dut.u_shifter.lfsr_q, 128'h55);
`ifdef OTP_DECRYPT_EN
      check($sformatf("hold_plain_%0d", i), bus.plain, m_prev);
`endif
      m_prev2 = m_prev;
      m_prev  = m_cur;
    end
    check("hold_cnt", dut.u_shifter.cnt_q, 128'd3);
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    step();
    check("resume_key_o", bus.key_o, 128'h33952A55);
`ifdef OTP_DECRYPT_EN
    check("resume_plain", bus.plain, m_prev);
`endif

    // key_ready with en toggling every cycle rises on the 16th enabled edge.
    restart(8'h33);
    step();
    n_en = 0;
    for (int c = 0; c < 34; c++) begin
      bus.en = (c % 2 == 0);
      step();
      if (c % 2 == 0) n_en++;
      check($sformatf("tog_ready_%0d", c), {127'b0, bus.key_ready}, {127'b0, n_en >= 16});
    end

    // Zero seed falls back to 0x01; keystream never hits zero and repeats every 255 bytes.
    bus.en = 1'b1;
    restart(8'h00);
    step();
    check("zero_lfsr_e1", dut.u_shifter.lfsr_q, 128'h01);
    step();
    zeros = 0;
    for (int i = 0; i < 299; i++) begin
      step();
      byts[i] = bus.key_o[7:0];
      if (byts[i] == 8'h00) zeros++;
    end
    check("zero_b0", byts[0], 128'h01);
    check("zero_b1", byts[1], 128'h64);
    check("zero_nonzero", zeros, '0);
    per_bad   = 0;
    early_rep = 0;
    for (int i = 0; i + 255 < 299; i++) begin
      if (byts[i] != byts[i + 255]) per_bad++;
    end
    for (int i = 1; i < 255; i++) begin
      if (byts[i] == byts[0]) early_rep++;
    end
    check("zero_period", per_bad, '0);
    check("zero_no_short", early_rep, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/one_time_pad.md
Name: one_time_pad

Overview:
- Stream cipher block. An internal 8-bit LFSR keystream generator expands an 8-bit seed into a TEXT_W-bit one-time-pad key register.
- Each cycle the block outputs the registered XOR of the message with the current key, plus the exact key used, so a downstream stage can decrypt.
- Sits between the message source and the transmit/loopback path; decryption of the output with the same key recovers the message.

Parameters:
- TEXT_W, 128, message/key width in bits; must be a multiple of 8 and at least 8.
- LFSR_TAPS, 8'hB8, Galois tap mask (x^8+x^6+x^5+x^4+1, maximal length 255).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = asserted).
- en  in  1  advance keystream this cycle.
- seed  in  8  LFSR seed; sampled on the first clock after reset release.
- msg  in  TEXT_W  plaintext (ASCII, MSB = first character).
- cipher  out  TEXT_W  registered msg XOR key.
- key_o  out  TEXT_W  key value used to produce the current cipher (same-cycle aligned).
- key_ready  out  1  high once the key register has been fully generated.

Behaviour:
- Reset asserted (async): lfsr=0, key=0, cipher=0, key_o=0, fill count=0, key_ready=0, state UNSEEDED.
- State UNSEEDED, first posedge after release:
  - lfsr <= seed, or 8'h01 if seed==0.
  - key holds 0. en is ignored this cycle. State goes to RUN.
- State RUN, posedge with en=1:
  - key <= {key[TEXT_W-9:0], lfsr}, i.e. the current LFSR byte is shifted into the LSB byte.
  - lfsr <= lfsr advanced 8 Galois steps. One step: s = s[0] ? (s>>1)^LFSR_TAPS : s>>1.
  - Fill count increments, saturating at TEXT_W/8.
- State RUN, posedge with en=0: lfsr, key and fill count hold.
- key_ready = 1 when fill count == TEXT_W/8. It stays 1 until reset.
- Cipher stage, every posedge in both states, independent of en:
  - cipher <= msg ^ key, using the key value before the edge.
  - key_o <= that same key value.
  - Latency is 1 cycle from msg to cipher.
- Decryption rule: cipher ^ key_o equals the msg sampled one edge earlier, regardless of en toggling.
- Reset mid-operation: all state clears immediately. The next release re-samples seed, so the keystream restarts deterministically.
- The LFSR never reaches 0 in RUN. The seed==0 substitution guarantees this.

Optional Feature:
- Macro OTP_DECRYPT_EN.
- When defined, adds output plain (out, TEXT_W): plain <= cipher ^ key_o at every posedge, reset to 0. This gives 2-cycle msg-to-plain loopback latency for self-check.
- When not defined, the port and its logic are absent.

Decomposition:
- Package otp_pkg holds:
  - constants LFSR_W=8, DEFAULT_TAPS=8'hB8, SEED_FALLBACK=8'h01;
  - function lfsr_step8 (8 Galois steps);
  - enum otp_state_t {UNSEEDED, RUN}.
- One sub-module, otp_shifter: LFSR, key register, fill counter and key_ready, with ports clk, reset, en, seed, key, key_ready.
- The top holds the XOR/cipher registers (and plain when OTP_DECRYPT_EN is defined).

Test Plan:
- Seed load: seed=8'h33, release reset, en=1 → after edge 1 lfsr=8'h33 and key=0. After edge 2 key[7:0]=8'h33 and lfsr=8'h95. After edge 3 key[15:0]=16'h3395.
- Zero seed: seed=8'h00, release reset → lfsr=8'h01 after the first edge and never 0 over 300 enabled cycles. The sequence repeats with period 255.
- Cipher/round-trip: msg="Hello World!!!!!" held, en=1 → each cycle cipher ^ key_o == msg. cipher==msg on the edge where key_o==0.
- Enable hold: drop en for 5 cycles mid-fill → key, lfsr and fill count are frozen, while cipher still updates when msg changes. Resuming continues the same sequence.
- key_ready: TEXT_W=128, en=1 → key_ready rises exactly 16 enabled cycles after seeding and stays high. With en toggling 50%, it rises after 16 enabled cycles.
- Async reset mid-run: drop reset between edges → all outputs become 0 immediately. After release with seed=8'h33, the key sequence matches the first scenario. With OTP_DECRYPT_EN defined, plain == msg delayed 2 cycles.
